pcie: RTL and testbench

//  Simplified PCIe-style transmit path with 4 virtual-channel (VC) byte FIFOs.

---
 rtl/pcie_pkg.sv | 21 ++
 rtl/pcie_vc_fifo.sv | 54 +++++
 rtl/pcie.sv | 123 ++++++++++++
 tb/tb_pcie.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pcie_pkg.sv
// Shared constants, CONTROL bit indices and FSM state encoding for the pcie transmit path.
// The build option PCIE_ROUND_ROBIN_EN (used in pcie.sv) selects round-robin VC arbitration.
package pcie_pkg;

    localparam int DATA_W     = 8;
    localparam int NUM_VC     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int VC_W       = $clog2(NUM_VC);

    localparam int CTL_VC_LSB = 0;
    localparam int CTL_WR     = 2;
    localparam int CTL_EG     = 3;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

endpackage

// File: rtl/pcie_vc_fifo.sv
// Single virtual-channel byte FIFO with show-ahead output; the parent never pushes
// when full unless it pops in the same cycle, and never pops when empty.
module pcie_vc_fifo
    import pcie_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Pointer and occupancy tracking; flush empties the FIFO without touching storage.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop)  rd_ptr_r <= rd_ptr_r + PW'(1);
            count_r <= count_r + CW'(push) - CW'(pop);
        end
    end

    // Byte storage; contents are only meaningful between the pointers.
    always_ff @(posedge CLK) begin
        if (push) mem_r[wr_ptr_r] <= din;
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));

endmodule

// File: rtl/pcie.sv
// Transmit path: write demux into NUM_VC byte FIFOs, arbiter, FSM and registered egress.
// Define PCIE_ROUND_ROBIN_EN for round-robin arbitration; otherwise VC0 has fixed priority.
module pcie
    import pcie_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic              RESET,
    input  logic [3:0]        CONTROL,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] DATA,
    output logic              VALID_OUT
);

    state_t             state_r;
    logic [NUM_VC-1:0]  push_s;
    logic [NUM_VC-1:0]  pop_s;
    logic [NUM_VC-1:0]  full_s;
    logic [NUM_VC-1:0]  empty_s;
    logic [DATA_W-1:0]  dout_s [NUM_VC];
    logic               wr_en_s;
    logic [VC_W-1:0]    wr_vc_s;
    logic               eg_ok_s;
    logic               ovf_s;
    logic               all_empty_s;
    logic               pop_any_s;
    logic [VC_W-1:0]    pop_vc_s;
    logic [VC_W-1:0]    base_s;
    logic [VC_W-1:0]    idx_s;
    logic               hit_s;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        pcie_vc_fifo u_fifo (
            .CLK   (CLK),
            .reset (reset),
            .flush (RESET),
            .push  (push_s[v]),
            .pop   (pop_s[v]),
            .din   (DATA_IN),
            .dout  (dout_s[v]),
            .full  (full_s[v]),
            .empty (empty_s[v])
        );
    end

    assign wr_en_s     = CONTROL[CTL_WR] && (state_r == ST_IDLE || state_r == ST_ACTIVE);
    assign wr_vc_s     = CONTROL[CTL_VC_LSB +: VC_W];
    assign eg_ok_s     = CONTROL[CTL_EG] && (state_r == ST_ACTIVE);
    assign all_empty_s = &empty_s;
    // A pop of the target VC in the same cycle frees the slot, so that write is legal.
    assign ovf_s       = wr_en_s && full_s[wr_vc_s] && !(pop_any_s && (pop_vc_s == wr_vc_s));
    assign push_s      = (wr_en_s && !ovf_s) ? (NUM_VC'(1) << wr_vc_s) : {NUM_VC{1'b0}};

`ifdef PCIE_ROUND_ROBIN_EN
    logic [VC_W-1:0] last_r;

    // Remembers the last granted VC so the search starts just after it.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            last_r <= VC_W'(NUM_VC - 1);
        end else if (RESET) begin
            last_r <= VC_W'(NUM_VC - 1);
        end else if (pop_any_s) begin
            last_r <= pop_vc_s;
        end
    end

    assign base_s = last_r + VC_W'(1);
`else
    assign base_s = VC_W'(0);
`endif

    // Arbiter: first non-empty VC scanning upward from base_s, wrapping.
    always_comb begin
        pop_any_s = 1'b0;
        pop_vc_s  = VC_W'(0);
        idx_s     = VC_W'(0);
        hit_s     = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            idx_s     = base_s + VC_W'(i);
            hit_s     = eg_ok_s && !pop_any_s && !empty_s[idx_s];
            pop_vc_s  = hit_s ? idx_s : pop_vc_s;
            pop_any_s = pop_any_s | hit_s;
        end
        pop_s = pop_any_s ? (NUM_VC'(1) << pop_vc_s) : {NUM_VC{1'b0}};
    end

    // Link state machine; ERROR is sticky until a hard or soft reset.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r <= ST_INIT;
        end else if (RESET) begin
            state_r <= ST_INIT;
        end else begin
            case (state_r)
                ST_INIT:   state_r <= ST_IDLE;
                ST_IDLE:   state_r <= ovf_s ? ST_ERROR : (wr_en_s ? ST_ACTIVE : ST_IDLE);
                ST_ACTIVE: begin
                    if (ovf_s)                         state_r <= ST_ERROR;
                    else if (all_empty_s && !wr_en_s)  state_r <= ST_IDLE;
                    else                               state_r <= ST_ACTIVE;
                end
                ST_ERROR:  state_r <= ST_ERROR;
                default:   state_r <= ST_ERROR;
            endcase
        end
    end

    // Egress registers; idle cycles drive zero data.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            DATA      <= {DATA_W{1'b0}};
            VALID_OUT <= 1'b0;
        end else if (RESET) begin
            DATA      <= {DATA_W{1'b0}};
            VALID_OUT <= 1'b0;
        end else begin
            DATA      <= pop_any_s ? dout_s[pop_vc_s] : {DATA_W{1'b0}};
            VALID_OUT <= pop_any_s;
        end
    end

endmodule

// File: tb/tb_pcie.sv
// Self-checking bench for pcie: directed scenarios plus random traffic against a queue-based model.
module tb_pcie;
    import pcie_pkg::*;

    logic       CLK;
    logic       reset;
    logic       RESET;
    logic [3:0] CONTROL;
    logic [7:0] DATA_IN;
    logic [7:0] DATA;
    logic       VALID_OUT;

    int checks_cnt = 0;
    int errors_cnt = 0;

    typedef logic [7:0] byte_q_t [$];
    byte_q_t    mq [4];
    state_t     m_st;
    logic [7:0] m_data;
    logic       m_valid;
    int         m_last;

    pcie dut (
        .CLK       (CLK),
        .reset     (reset),
        .RESET     (RESET),
        .CONTROL   (CONTROL),
        .DATA_IN   (DATA_IN),
        .DATA      (DATA),
        .VALID_OUT (VALID_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_init();
        for (int v = 0; v < 4; v++) mq[v].delete();
        m_st    = ST_INIT;
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_last  = 3;
    endfunction

    // Applies one clock edge of the spec's rules to the queue model.
    function automatic void model_step();
        int  sz [4];
        int  wv, pv, v, total;
        bit  wr, popped, ovf;
        if (RESET) begin
            model_init();
            return;
        end
        total = 0;
        for (int k = 0; k < 4; k++) begin
            sz[k] = mq[k].size();
            total += sz[k];
        end
        wr = CONTROL[2] && (m_st == ST_IDLE || m_st == ST_ACTIVE);
        wv = int'(CONTROL[1:0]);
        popped = 1'b0;
        pv = 0;
        if (CONTROL[3] && m_st == ST_ACTIVE) begin
            for (int k = 0; k < 4; k++) begin
`ifdef PCIE_ROUND_ROBIN_EN
                v = (m_last + 1 + k) % 4;
`else
                v = k;
`endif
                if (!popped && sz[v] > 0) begin
                    popped = 1'b1;
                    pv = v;
                end
            end
        end
        m_valid = popped;
        m_data  = 8'h00;
        if (popped) begin
            m_data = mq[pv].pop_front();
            m_last = pv;
        end
        ovf = wr && (sz[wv] == 4) && !(popped && pv == wv);
        if (wr && !ovf) mq[wv].push_back(DATA_IN);
        case (m_st)
            ST_INIT:   m_st = ST_IDLE;
            ST_IDLE:   m_st = ovf ? ST_ERROR : (wr ? ST_ACTIVE : ST_IDLE);
            ST_ACTIVE: m_st = ovf ? ST_ERROR : ((total == 0 && !wr) ? ST_IDLE : ST_ACTIVE);
            default:   m_st = ST_ERROR;
        endcase
    endfunction

    // Drives inputs on the falling edge, models the rising edge, checks on the next falling edge.
    task automatic drive_cycle(input logic [3:0] ctl, input logic [7:0] din, input logic srst);
        CONTROL = ctl;
        DATA_IN = din;
        RESET   = srst;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check_val("data", 32'(DATA), 32'(m_data));
        check_val("valid", 32'(VALID_OUT), 32'(m_valid));
        check_val("state", 32'(dut.state_r), 32'(m_st));
    endtask

    initial begin
        reset   = 1'b0;
        RESET   = 1'b0;
        CONTROL = 4'h0;
        DATA_IN = 8'hFF;
        model_init();

        // Hard reset state
        #12;
        check_val("rst_data", 32'(DATA), 32'h0);
        check_val("rst_valid", 32'(VALID_OUT), 32'h0);
        check_val("rst_state", 32'(dut.state_r), 32'(ST_INIT));
        @(negedge CLK);
        reset = 1'b1;
        drive_cycle(4'b0000, 8'hFF, 1'b0);
        check_val("init_to_idle", 32'(dut.state_r), 32'(ST_IDLE));

        // Single VC0 byte, 2-cycle latency
        drive_cycle(4'b0100, 8'hFF, 1'b0);
        check_val("t2_no_early", 32'(VALID_OUT), 32'h0);
        drive_cycle(4'b1000, 8'h00, 1'b0);
        check_val("t2_data", 32'(DATA), 32'hFF);
        check_val("t2_valid", 32'(VALID_OUT), 32'h1);
        drive_cycle(4'b1000, 8'h00, 1'b0);
        check_val("t2_one_shot", 32'(VALID_OUT), 32'h0);

        // Overflow on VC2
        for (int i = 0; i < 5; i++) drive_cycle(4'b0110, 8'(8'h20 + i), 1'b0);
        check_val("t3_error", 32'(dut.state_r), 32'(ST_ERROR));
        drive_cycle(4'b1000, 8'h00, 1'b0);
        check_val("t3_frozen", 32'(VALID_OUT), 32'h0);
        drive_cycle(4'b1000, 8'h00, 1'b1);
        check_val("t3_srst", 32'(dut.state_r), 32'(ST_INIT));
        drive_cycle(4'b1000, 8'h00, 1'b0);
        check_val("t3_flushed", 32'(VALID_OUT), 32'h0);

        // Priority: VC1 before VC3
        drive_cycle(4'b0111, 8'hA3, 1'b0);
        drive_cycle(4'b0101, 8'hB1, 1'b0);
        drive_cycle(4'b1000, 8'h00, 1'b0);
        check_val("t4_first", 32'(DATA), 32'hB1);
        drive_cycle(4'b1000, 8'h00, 1'b0);
        check_val("t4_second", 32'(DATA), 32'hA3);
        drive_cycle(4'b0000, 8'h00, 1'b0);

        // Full VC0 with simultaneous write and pop
        for (int i = 0; i < 4; i++) drive_cycle(4'b0100, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_cycle(4'b1100, 8'(8'h50 + i), 1'b0);
            check_val("t5_valid", 32'(VALID_OUT), 32'h1);
            check_val("t5_state", 32'(dut.state_r), 32'(ST_ACTIVE));
        end

        // Asynchronous reset mid-stream
        check_val("t6_pre", 32'(VALID_OUT), 32'h1);
        reset = 1'b0;
        #1;
        check_val("t6_data", 32'(DATA), 32'h0);
        check_val("t6_valid", 32'(VALID_OUT), 32'h0);
        check_val("t6_state", 32'(dut.state_r), 32'(ST_INIT));
        model_init();
        CONTROL = 4'h0;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b1;

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            logic [3:0] ctl;
            ctl    = 4'($urandom);
            ctl[3] = ($urandom_range(0, 3) != 0);
            drive_cycle(ctl, 8'($urandom), ($urandom_range(0, 39) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
